// File: rtl/uart_tx_status.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_status
//  Purpose  : 8N1 UART transmitter (LSB first) with a byte FIFO in front.
//             Returns status/acknowledge bytes from the FPGA to the host.
//             Queued bytes are sent back-to-back with no idle gap.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_status #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    c_FULL      = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready_en;

    // Serializer state
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_baud_end;
    logic [7:0] w_head;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    // ready is held low until the first edge after reset release
    assign ready  = r_ready_en & ~w_full;
    assign w_push = valid & ready;

    // The serializer takes the head byte when idle, or at the very end of a
    // stop bit so the next start bit follows without a gap.
    assign w_pop = ~w_empty &
                   ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_end));

    assign tx         = r_tx;
    assign fifo_count = r_count;
    assign busy       = (r_state != c_IDLE) || ~w_empty;

    // Arm the ready output once reset has been released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // FIFO data array: written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Frame serializer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= c_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                c_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            // next bit is the one about to shift into bit 0
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                c_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= c_START;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_status.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_status
//  Purpose  : Self-checking bench for uart_tx_status (CLKS_PER_BIT=4,
//             FIFO_DEPTH=4). A scoreboard queue collects accepted bytes and a
//             serial monitor decodes tx and compares against it; directed
//             sequences check cycle-exact timing and corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_status;

    localparam int c_CPB   = 4;
    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         data_in;
    logic               valid;
    logic               ready;
    logic               tx;
    logic               busy;
    logic [c_CNT_W-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_status #(
        .CLKS_PER_BIT(c_CPB),
        .FIFO_DEPTH  (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid     (valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       mon_active = 1'b0;
    int         mon_off    = 0;
    logic [7:0] mon_byte   = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit j = tx level during frame bit j
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that pushed the byte; checks 40 cycles of tx
    task automatic check_frame(input string nm, input logic [9:0] frame);
        for (int k = 0; k < 10 * c_CPB; k++) begin
            tick();
            valid = 1'b0;
            chk(nm, 32'(tx), 32'(frame[4'(k / c_CPB)]));
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int         nxt;
        logic       rdy;
        logic [9:0] fr;

        rst     = 1'b0;
        valid   = 1'b0;
        data_in = 8'h00;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h81, frame: 10'b1100000010};

        fork
            // scoreboard: record every accepted byte; reset discards all
            forever begin
                @(posedge clk);
                if (!rst) begin
                    exp_q.delete();
                end else if (valid && ready) begin
                    exp_q.push_back(data_in);
                end
            end
            // serial monitor: decode frames sampled on the falling edge
            forever begin
                @(negedge clk);
                if (!rst) begin
                    mon_active = 1'b0;
                end else if (!mon_active) begin
                    if (tx === 1'b0) begin
                        mon_active = 1'b1;
                        mon_off    = 0;
                    end
                end else begin
                    mon_off++;
                    if (mon_off < c_CPB) begin
                        chk("mon_start_bit", 32'(tx), 32'd0);
                    end else if (mon_off < 9 * c_CPB) begin
                        if ((mon_off % c_CPB) == 2) begin
                            mon_byte[3'((mon_off - c_CPB) / c_CPB)] = tx;
                        end
                    end else if (mon_off == 9 * c_CPB + 2) begin
                        chk("mon_stop_bit", 32'(tx), 32'd1);
                    end
                    if (mon_off == 10 * c_CPB - 1) begin
                        mon_active = 1'b0;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL sb_unexpected_frame: got %0h expected none", mon_byte);
                        end else begin
                            total--;
                            chk("sb_byte_order", 32'(mon_byte), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        // ---------------- reset / idle ----------------
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_count", 32'(fifo_count), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
        end
        rst = 1'b1;
        chk("ready_before_first_edge", 32'(ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(ready), 32'd1);
        chk("idle_tx", 32'(tx), 32'd1);
        tick();

        // ---------------- single-byte table ----------------
        for (int i = 0; i < 4; i++) begin
            valid   = 1'b1;
            data_in = vecs[i].data;
            tick();                       // edge E: push
            valid = 1'b0;
            chk("vec_count_after_push", 32'(fifo_count), 32'd1);
            chk("vec_tx_idle_at_E", 32'(tx), 32'd1);
            check_frame("vec_frame_bit", vecs[i].frame);   // edges E+1..E+40
            chk("vec_busy_last_stop", 32'(busy), 32'd1);
            tick();                       // edge E+41
            chk("vec_busy_drop", 32'(busy), 32'd0);
            chk("vec_tx_idle_after", 32'(tx), 32'd1);
            tick();
            tick();
        end

        // ---------------- back-to-back 0x55, 0x0F ----------------
        valid   = 1'b1;
        data_in = 8'h55;
        tick();                           // E
        chk("b2b_count_E", 32'(fifo_count), 32'd1);
        data_in = 8'h0F;                  // pushed at E+1, inside check_frame
        check_frame("b2b_frame0", 10'b1010101010);
        chk("b2b_count_E40", 32'(fifo_count), 32'd1);
        check_frame("b2b_frame1_no_gap", 10'b1000011110);
        tick();
        chk("b2b_count_end", 32'(fifo_count), 32'd0);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        tick();

        // ---------------- overflow: hold valid, push 0x01..0x06 ----------------
        nxt   = 1;
        valid = 1'b1;
        for (int c = 0; c < 600 && nxt <= 6; c++) begin
            data_in = 8'(nxt);
            rdy     = ready;
            tick();
            if (rdy) begin
                if (nxt == 5) begin
                    chk("ovf_count_full", 32'(fifo_count), 32'd4);
                    chk("ovf_ready_low", 32'(ready), 32'd0);
                end
                nxt++;
            end
        end
        valid = 1'b0;
        chk("ovf_all_pushed", 32'(nxt), 32'd7);
        wait_idle(400);
        tick();

        // ---------------- push on the STOP-end pop edge, count 2 ----------------
        valid   = 1'b1;
        data_in = 8'hC3;
        tick();                           // E
        data_in = 8'h5A;
        tick();                           // E+1 (pop C3, push 5A)
        data_in = 8'h96;
        tick();                           // E+2
        valid = 1'b0;
        chk("same_count_2", 32'(fifo_count), 32'd2);
        repeat (38) tick();               // now after E+40
        chk("same_stop_tx", 32'(tx), 32'd1);
        valid   = 1'b1;
        data_in = 8'h69;
        tick();                           // E+41: pop and push together
        valid = 1'b0;
        chk("same_count_kept", 32'(fifo_count), 32'd2);
        chk("same_start_now", 32'(tx), 32'd0);
        chk("same_busy", 32'(busy), 32'd1);
        wait_idle(400);
        tick();

        // ---------------- reset mid-frame (DATA bit 3, then START) ----------------
        for (int r = 0; r < 2; r++) begin
            valid   = 1'b1;
            data_in = 8'h3C;
            tick();                       // E
            data_in = 8'h11;
            tick();                       // E+1
            data_in = 8'h22;
            tick();                       // E+2
            valid = 1'b0;
            chk("mid_queued", 32'(fifo_count), 32'd2);
            if (r == 0) begin
                repeat (16) tick();       // after E+18: inside data bit 3
                chk("mid_data_bit3", 32'(tx), 32'd1);
            end else begin
                chk("mid_start_low", 32'(tx), 32'd0);
            end
            #2;
            rst = 1'b0;                   // between clock edges
            #1;
            chk("async_tx_high", 32'(tx), 32'd1);
            chk("async_count_zero", 32'(fifo_count), 32'd0);
            chk("async_busy_zero", 32'(busy), 32'd0);
            chk("async_ready_zero", 32'(ready), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            tick();
            chk("post_rst_ready", 32'(ready), 32'd1);
            fr = 10'h000;
            for (int k = 0; k < 60; k++) begin
                tick();
                if (tx !== 1'b1 || busy !== 1'b0) fr = fr + 10'd1;
            end
            chk("post_rst_no_residual", 32'(fr), 32'd0);
        end

        // ---------------- wrap-up ----------------
        repeat (4) tick();
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mon_not_mid_frame", 32'(mon_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
